// File: rtl/gtx_pkg.sv
// Shared types and constants for the 16-bit GTX receive framer.
package gtx_pkg;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} gtx_rx_state_t;

  localparam logic [15:0] K28_5_WORD = 16'hBCBC;
  localparam logic [1:0]  K28_5_CTRL = 2'b11;

  function automatic logic is_comma(input logic [1:0] ctrl, input logic [15:0] word);
    return (ctrl == K28_5_CTRL) && (word == K28_5_WORD);
  endfunction

endpackage

// File: rtl/gtx_rx_align.sv
// Byte-alignment front end: forms the aligned and one-byte-shifted candidate
// words, flags a comma on either, and muxes the selected alignment.
module gtx_rx_align
  import gtx_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_ctrl,
  input  logic [15:0] i_data,
  input  logic        i_shift,
  output logic        o_comma_a,
  output logic        o_comma_b,
  output logic [15:0] o_sel_word,
  output logic [1:0]  o_sel_ctrl
);

  // Only the later byte of the previous word feeds the shifted candidate.
  logic [7:0]  r_prev_hi;
  logic        r_prev_k1;
  logic [15:0] w_word_b;
  logic [1:0]  w_ctrl_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_hi <= '0;
      r_prev_k1 <= 1'b0;
    end else begin
      r_prev_hi <= i_data[15:8];
      r_prev_k1 <= i_ctrl[1];
    end
  end

  assign w_word_b   = {i_data[7:0], r_prev_hi};
  assign w_ctrl_b   = {i_ctrl[0], r_prev_k1};

  assign o_comma_a  = is_comma(i_ctrl, i_data);
  assign o_comma_b  = is_comma(w_ctrl_b, w_word_b);

  assign o_sel_word = i_shift ? w_word_b : i_data;
  assign o_sel_ctrl = i_shift ? w_ctrl_b : i_ctrl;

endmodule

// File: rtl/gtx_rx.sv
// GTX receive framer: comma-based word alignment, frame lock acquisition and
// monitoring, and comma stripping with a one-cycle registered payload path.
module gtx_rx
  import gtx_pkg::*;
#(
  parameter int COMMA_PERIOD = 16,
  parameter int LOCK_CNT     = 4,
  parameter int LOSS_CNT     = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  ctrl_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        lock_o,
  output logic        shift_o,
  output logic        err_o
);

  localparam int WW = $clog2(COMMA_PERIOD);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [WW-1:0] WLAST     = WW'(COMMA_PERIOD - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

  gtx_rx_state_t r_state, w_next;

  logic [WW-1:0] r_wcnt, w_wcnt_inc;
  logic [GW-1:0] r_good;
  logic [MW-1:0] r_miss;
  logic          r_shift;

  logic [15:0]   r_data;
  logic          r_valid, r_lock, r_err;
  logic          w_valid_nxt, w_lock_nxt, w_err_nxt;

  logic          w_comma_a, w_comma_b;
  logic [15:0]   w_sel_word;
  logic [1:0]    w_sel_ctrl;
  logic          w_slot0, w_sel_comma, w_good, w_bad;

  gtx_rx_align u_align (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_ctrl     (ctrl_i),
    .i_data     (data_i),
    .i_shift    (r_shift),
    .o_comma_a  (w_comma_a),
    .o_comma_b  (w_comma_b),
    .o_sel_word (w_sel_word),
    .o_sel_ctrl (w_sel_ctrl)
  );

  assign w_slot0     = (r_wcnt == '0);
  assign w_sel_comma = is_comma(w_sel_ctrl, w_sel_word);
  assign w_good      = w_slot0 && w_sel_comma;
  assign w_bad       = w_slot0 ? !w_sel_comma : (w_sel_ctrl != 2'b00);
  assign w_wcnt_inc  = (r_wcnt == WLAST) ? '0 : r_wcnt + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= HUNT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HUNT:    if (w_comma_a || w_comma_b) w_next = CHECK;
      CHECK:   if (w_bad) w_next = HUNT;
               else if (w_good && r_good == GOOD_LAST) w_next = LOCKED;
      LOCKED:  if (w_bad && r_miss == MISS_LAST) w_next = HUNT;
      default: w_next = HUNT;
    endcase
  end

  always_comb begin
    w_valid_nxt = (r_state == LOCKED) && !w_slot0 && (w_sel_ctrl == 2'b00);
    w_err_nxt   = (r_state == LOCKED) && w_bad;
    w_lock_nxt  = (w_next == LOCKED);
  end

  // Slot counter restarts at 0 on any return to HUNT; from HUNT, the
  // increment of 0 gives slot 1 for the word after the acquired comma.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wcnt  <= '0;
      r_good  <= '0;
      r_miss  <= '0;
      r_shift <= 1'b0;
    end else begin
      r_wcnt <= (w_next == HUNT) ? '0 : w_wcnt_inc;
      case (r_state)
        HUNT: begin
          r_miss <= '0;
          if (w_comma_a) begin
            r_shift <= 1'b0;
            r_good  <= GW'(1);
          end else if (w_comma_b) begin
            r_shift <= 1'b1;
            r_good  <= GW'(1);
          end else begin
            r_good  <= '0;
          end
        end
        CHECK: begin
          if (w_bad)       r_good <= '0;
          else if (w_good) r_good <= r_good + 1'b1;
          if (w_next == LOCKED) r_miss <= '0;
        end
        LOCKED: begin
          if (w_next == HUNT) begin
            r_good <= '0;
            r_miss <= '0;
          end else if (w_bad) begin
            r_miss <= r_miss + 1'b1;
          end else if (w_good) begin
            r_miss <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_lock  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_valid_nxt) r_data <= w_sel_word;
      r_valid <= w_valid_nxt;
      r_lock  <= w_lock_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign lock_o  = r_lock;
  assign err_o   = r_err;
  assign shift_o = r_shift;

endmodule

// File: tb/tb_gtx_rx.sv
// Directed self-checking bench for gtx_rx: alignment, lock, loss and reset.
module tb_gtx_rx;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [1:0]  ctrl_i = 2'b00;
  logic [15:0] data_i = 16'h0000;
  logic [15:0] data_o;
  logic        valid_o, lock_o, shift_o, err_o;

  int checks = 0;
  int errors = 0;

  // Stream generator state: shifted-wire mode and previous logical word.
  logic        sh = 1'b0;
  logic [15:0] pw = 16'h0000;
  logic [1:0]  pc = 2'b00;

  gtx_rx #(.COMMA_PERIOD(16), .LOCK_CNT(4), .LOSS_CNT(2)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .ctrl_i  (ctrl_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .lock_o  (lock_o),
    .shift_o (shift_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  // One word per cycle; returns #1 after the edge that consumed it.
  task automatic drive(input logic [15:0] w, input logic [1:0] c);
    @(negedge clk_i);
    if (sh) begin
      data_i = {w[7:0], pw[15:8]};
      ctrl_i = {c[0], pc[1]};
    end else begin
      data_i = w;
      ctrl_i = c;
    end
    pw = w;
    pc = c;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input bit bad);
    if (bad) drive(16'h1234, 2'b00);
    else     drive(16'hBCBC, 2'b11);
    for (int k = 1; k < 16; k++) drive(16'(k), 2'b00);
  endtask

  task automatic do_reset(input bit shifted);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    data_i = 16'h0000;
    ctrl_i = 2'b00;
    pw = 16'h0000;
    pc = 2'b00;
    sh = shifted;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic lock_aligned();
    do_reset(1'b0);
    repeat (4) send_frame(1'b0);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if ({data_o, valid_o, lock_o, shift_o, err_o} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b l=%b s=%b e=%b, want all 0",
               data_o, valid_o, lock_o, shift_o, err_o);
    end
  endtask

  task automatic test_aligned();
    int nv;
    do_reset(1'b0);
    repeat (3) send_frame(1'b0);
    checks++;
    if (lock_o !== 1'b0) begin errors++; $display("FAIL aligned_prelock: lock=%b want 0", lock_o); end
    drive(16'hBCBC, 2'b11);
    checks++;
    if (lock_o !== 1'b1 || shift_o !== 1'b0) begin
      errors++; $display("FAIL aligned_lock: lock=%b shift=%b want 1/0", lock_o, shift_o);
    end
    for (int k = 1; k < 16; k++) begin
      drive(16'(k), 2'b00);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 16'(k)) begin
        errors++; $display("FAIL aligned_data: v=%b data=%h want 1/%h", valid_o, data_o, 16'(k));
      end
    end
    drive(16'hBCBC, 2'b11);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL aligned_comma_strip: v=%b want 0", valid_o); end
    nv = 0;
    for (int k = 1; k < 16; k++) begin
      drive(16'(k), 2'b00);
      if (valid_o === 1'b1) nv++;
    end
    checks++;
    if (nv != 15) begin errors++; $display("FAIL aligned_count: got %0d want 15", nv); end
  endtask

  task automatic test_shifted();
    do_reset(1'b1);
    repeat (3) send_frame(1'b0);
    drive(16'hBCBC, 2'b11);
    checks++;
    if (lock_o !== 1'b0) begin errors++; $display("FAIL shifted_prelock: lock=%b want 0", lock_o); end
    drive(16'h0001, 2'b00);
    checks++;
    if (lock_o !== 1'b1 || shift_o !== 1'b1) begin
      errors++; $display("FAIL shifted_lock: lock=%b shift=%b want 1/1", lock_o, shift_o);
    end
    for (int k = 2; k < 16; k++) begin
      drive(16'(k), 2'b00);
      checks++;
      if (valid_o !== 1'b1 || data_o !== 16'(k - 1)) begin
        errors++; $display("FAIL shifted_data: v=%b data=%h want 1/%h", valid_o, data_o, 16'(k - 1));
      end
    end
    drive(16'hBCBC, 2'b11);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'h000F) begin
      errors++; $display("FAIL shifted_last: v=%b data=%h want 1/000f", valid_o, data_o);
    end
    drive(16'h0001, 2'b00);
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL shifted_comma_strip: v=%b want 0", valid_o); end
    sh = 1'b0;
  endtask

  task automatic test_single_miss();
    int nv;
    lock_aligned();
    drive(16'h1234, 2'b00);
    checks++;
    if (err_o !== 1'b1 || lock_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL miss1_err: e=%b l=%b v=%b want 1/1/0", err_o, lock_o, valid_o);
    end
    nv = 0;
    for (int k = 1; k < 16; k++) begin
      drive(16'(k), 2'b00);
      if (k == 1) begin
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL miss1_pulse_width: e=%b want 0", err_o); end
      end
      if (valid_o === 1'b1 && data_o === 16'(k)) nv++;
    end
    checks++;
    if (nv != 15) begin errors++; $display("FAIL miss1_payload: got %0d want 15", nv); end
    drive(16'hBCBC, 2'b11);
    checks++;
    if (lock_o !== 1'b1 || err_o !== 1'b0) begin
      errors++; $display("FAIL miss1_recover: l=%b e=%b want 1/0", lock_o, err_o);
    end
  endtask

  task automatic test_loss_relock();
    int nv;
    lock_aligned();
    send_frame(1'b1);
    drive(16'h1234, 2'b00);
    checks++;
    if (err_o !== 1'b1 || lock_o !== 1'b0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL loss_drop: e=%b l=%b v=%b want 1/0/0", err_o, lock_o, valid_o);
    end
    nv = 0;
    for (int k = 1; k < 16; k++) begin
      drive(16'(k), 2'b00);
      if (valid_o !== 1'b0 || err_o !== 1'b0) nv++;
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL loss_quiet: got %0d active cycles want 0", nv); end
    repeat (3) send_frame(1'b0);
    checks++;
    if (lock_o !== 1'b0) begin errors++; $display("FAIL loss_prerelock: lock=%b want 0", lock_o); end
    drive(16'hBCBC, 2'b11);
    checks++;
    if (lock_o !== 1'b1) begin errors++; $display("FAIL loss_relock: lock=%b want 1", lock_o); end
  endtask

  task automatic test_check_abort();
    do_reset(1'b0);
    send_frame(1'b0);
    drive(16'hBCBC, 2'b11);
    for (int k = 1; k < 7; k++) drive(16'(k), 2'b00);
    drive(16'hBCBC, 2'b11);
    for (int k = 8; k < 16; k++) drive(16'(k), 2'b00);
    repeat (3) send_frame(1'b0);
    checks++;
    if (lock_o !== 1'b0) begin errors++; $display("FAIL abort_nolock: lock=%b want 0", lock_o); end
    drive(16'hBCBC, 2'b11);
    checks++;
    if (lock_o !== 1'b1) begin errors++; $display("FAIL abort_relock: lock=%b want 1", lock_o); end
  endtask

  task automatic test_async_reset();
    lock_aligned();
    drive(16'hBCBC, 2'b11);
    for (int k = 1; k < 6; k++) drive(16'(k), 2'b00);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({data_o, valid_o, lock_o, shift_o, err_o} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset: data=%h v=%b l=%b s=%b e=%b want all 0",
               data_o, valid_o, lock_o, shift_o, err_o);
    end
    @(negedge clk_i);
    pw = 16'h0000;
    pc = 2'b00;
    data_i = 16'h0000;
    ctrl_i = 2'b00;
    rst_n_i = 1'b1;
    repeat (3) send_frame(1'b0);
    checks++;
    if (lock_o !== 1'b0) begin errors++; $display("FAIL async_prelock: lock=%b want 0", lock_o); end
    drive(16'hBCBC, 2'b11);
    checks++;
    if (lock_o !== 1'b1) begin errors++; $display("FAIL async_relock: lock=%b want 1", lock_o); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_shifted();
    test_single_miss();
    test_loss_relock();
    test_check_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gtx_rx.md
Name: gtx_rx

Overview:
Receive-side framer for the 16-bit GTX link. Its transmit counterpart sends a K28.5 comma word (data 16'hBCBC, ctrl 2'b11) once every COMMA_PERIOD words. This block sits directly after the transceiver RX port (8b/10b-decoded data and K-flags). It performs three jobs:
- Recovers 16-bit word alignment when the stream arrives shifted by one byte.
- Acquires and monitors frame lock against the periodic comma.
- Strips commas and delivers payload words with a valid strobe.

Parameters:
COMMA_PERIOD, 16, words per frame including the comma slot (must be ≥ 4).
LOCK_CNT, 4, consecutive correctly spaced commas required to declare lock.
LOSS_CNT, 2, consecutive bad comma slots required to drop lock.

Ports:
clk_i  in  1  RX user clock.
rst_n_i  in  1  reset, asynchronous, active-low.
ctrl_i  in  2  K-flags from transceiver; bit0 marks data_i[7:0] (first byte on wire), bit1 marks data_i[15:8].
data_i  in  16  decoded RX word.
data_o  out  16  aligned payload word.
valid_o  out  1  data_o carries a new payload word this cycle.
lock_o  out  1  frame lock held.
shift_o  out  1  current alignment is the one-byte-shifted alignment.
err_o  out  1  one-cycle pulse for each bad comma slot while LOCKED.

Behaviour:
Reset values
- All outputs 0.
- State HUNT; counters 0; prev register 0.

Prev register
- prev_ctrl/prev_data are loaded with ctrl_i/data_i every cycle.

Alignment candidates (combinational)
- A: word = data_i, ctrl = ctrl_i.
- B: word = {data_i[7:0], prev_data[15:8]}, ctrl = {ctrl_i[0], prev_ctrl[1]}.
- comma_x: candidate ctrl == 2'b11 and candidate word == 16'hBCBC.
- The selected word/ctrl (sel) is A when shift = 0, B when shift = 1.

Slot counter
- wcnt has width $clog2(COMMA_PERIOD).
- It advances every cycle and wraps from COMMA_PERIOD-1 to 0.
- Slot 0 is the expected comma slot.
- A slot is **good** when sel is a comma at wcnt == 0.
- A slot is **bad** when either:
  - wcnt == 0 and sel is not a comma, or
  - wcnt != 0 and sel ctrl != 2'b00.

State machine (registered)
- HUNT:
  - If comma_A, then shift ← 0.
  - Else if comma_B, then shift ← 1.
  - Either way: wcnt ← 1, good ← 1, next state CHECK.
  - If both candidates show a comma, A is preferred.
  - Otherwise stay in HUNT; wcnt is held at 0.
- CHECK:
  - A good slot increments good. When good reaches LOCK_CNT, go to LOCKED and set miss ← 0.
  - Any bad slot returns to HUNT with good ← 0.
  - shift is frozen.
- LOCKED:
  - A good slot clears miss.
  - A bad slot increments miss and pulses err_o on the next cycle.
  - When miss reaches LOSS_CNT, return to HUNT.
  - shift is frozen.
- lock_o is registered and equals (state == LOCKED). It rises one cycle after the LOCK_CNT-th good comma and falls one cycle after the LOSS_CNT-th bad slot.

Output path (latency 1 cycle from the cycle the completing byte arrives)
- If state is LOCKED, wcnt != 0 and sel ctrl == 2'b00: data_o ← sel word, valid_o ← 1.
- Otherwise valid_o ← 0 and data_o holds its last value.
- The comma slot never produces valid_o.
- A K-character in a data slot is dropped (valid_o = 0) and counts as bad.
- The word in the cycle that causes the drop from LOCKED to HUNT is not output.

Boundary conditions
- An asynchronous reset mid-frame clears everything at once; re-acquisition starts from HUNT.
- The bad-slot and wrap conditions are evaluated on the same cycle edge; the transition takes priority over counter updates.
- shift_o mirrors the shift register.

Decomposition:
Package gtx_pkg holds:
- typedef enum logic [1:0] {HUNT, CHECK, LOCKED} gtx_rx_state_t;
- localparam K28_5_WORD = 16'hBCBC;
- localparam K28_5_CTRL = 2'b11.

One natural sub-module, gtx_rx_align, contains:
- the prev register;
- candidate A/B formation and comma_A/comma_B detection;
- the sel mux, driven by shift.

The top level holds the FSM, counters and output registers.

Test Plan:
1. Aligned stream, 16'hBCBC/2'b11 every 16 words, payload 16'h0001..16'h000F. After the 4th comma, lock_o = 1 with shift_o = 0. Then exactly 15 valid_o pulses per frame, and data_o = 16'h0001..16'h000F one cycle after input.
2. Same stream offset by one byte, with leading byte 8'h00 and ctrl shifted accordingly. Required: shift_o = 1 and lock_o = 1 after 4 commas, and data_o reconstructs 16'h0001..16'h000F in order.
3. While LOCKED, one comma replaced by 16'h1234/2'b00. Required: a single err_o pulse; lock_o stays 1; the following 15 payload words are delivered.
4. While LOCKED, two consecutive commas replaced by data. Required: err_o pulses twice; lock_o = 0 one cycle after the second; valid_o stays 0; relock after 4 further good commas.
5. In CHECK after 2 good commas, a comma inserted at wcnt = 7. Required: return to HUNT, lock_o stays 0, and LOCK_CNT fresh good commas are needed before lock_o = 1.
6. Assert rst_n_i low mid-frame while LOCKED. Required: lock_o, valid_o, err_o, shift_o and data_o all 0 immediately; after release, lock reacquired after 4 commas.
